lut_neuron_table_loader: RTL and testbench

//  Writer side of a LogicNet neuron truth table. It fills a 2^IN_BITS x OUT_BITS distributed-RAM table from a

---
 rtl/lut_neuron_pkg.sv | 12 +
 rtl/lut_neuron_ram.sv | 31 +++
 rtl/lut_neuron_table_loader.sv | 91 +++++++++
 tb/tb_lut_neuron_table_loader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg: shared sizing constants and loader state type for the LUT neuron table loader
//   DEF_*   default neuron geometry
//   NBEATS  config beats per full table load
//   CFG_W   config beat width in bits
package lut_neuron_pkg;
    localparam int DEF_IN_BITS      = 6;
    localparam int DEF_OUT_BITS     = 2;
    localparam int DEF_BEAT_ENTRIES = 4;
    localparam int NBEATS           = (2 ** DEF_IN_BITS) / DEF_BEAT_ENTRIES;
    localparam int CFG_W            = DEF_OUT_BITS * DEF_BEAT_ENTRIES;
    typedef enum logic [1:0] {IDLE, LOAD, ARMED} ldr_state_e;
endpackage

// File: rtl/lut_neuron_ram.sv
// lut_neuron_ram: 2**IN_BITS x OUT_BITS distributed RAM, beat-wide write, one synchronous read
//   clk    clock
//   we     write one beat (BEAT_ENTRIES consecutive entries)
//   waddr  beat index
//   wdata  packed entries, entry k at [k*OUT_BITS +: OUT_BITS]
//   re     read enable
//   raddr  entry address
//   rdata  registered read data
module lut_neuron_ram #(
    parameter int IN_BITS      = 6,
    parameter int OUT_BITS     = 2,
    parameter int BEAT_ENTRIES = 4
) (
    input  logic                                    clk,
    input  logic                                    we,
    input  logic [IN_BITS-$clog2(BEAT_ENTRIES)-1:0] waddr,
    input  logic [OUT_BITS*BEAT_ENTRIES-1:0]        wdata,
    input  logic                                    re,
    input  logic [IN_BITS-1:0]                      raddr,
    output logic [OUT_BITS-1:0]                     rdata
);
    logic [OUT_BITS-1:0] mem [2**IN_BITS];

    always_ff @(posedge clk) begin
        if (we)
            for (int k = 0; k < BEAT_ENTRIES; k++)
                mem[IN_BITS'(int'(waddr) * BEAT_ENTRIES + k)] <= wdata[k*OUT_BITS +: OUT_BITS];
        if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/lut_neuron_table_loader.sv
// lut_neuron_table_loader: loads a neuron truth table from a config stream and serves 1-cycle lookups
//   clk, rst_n              clock, async active-low reset
//   cfg_start               begin/restart a table load
//   cfg_valid/ready/data    config beat handshake and payload
//   cfg_last                final beat marker
//   cfg_err                 sticky framing error, cleared by cfg_start
//   tbl_ready               table loaded, lookups enabled
//   M0, m0_valid            lookup request
//   M1, m1_valid            lookup result, zero when not valid
module lut_neuron_table_loader import lut_neuron_pkg::*; #(
    parameter int IN_BITS      = DEF_IN_BITS,
    parameter int OUT_BITS     = DEF_OUT_BITS,
    parameter int BEAT_ENTRIES = DEF_BEAT_ENTRIES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_start,
    input  logic                             cfg_valid,
    output logic                             cfg_ready,
    input  logic [OUT_BITS*BEAT_ENTRIES-1:0] cfg_data,
    input  logic                             cfg_last,
    output logic                             cfg_err,
    output logic                             tbl_ready,
    input  logic [IN_BITS-1:0]               M0,
    input  logic                             m0_valid,
    output logic [OUT_BITS-1:0]              M1,
    output logic                             m1_valid
);
    localparam int BW = IN_BITS - $clog2(BEAT_ENTRIES);

    ldr_state_e          state, state_n;
    logic [BW-1:0]       beat_cnt, beat_cnt_n;
    logic                err_n, we, re;
    logic [OUT_BITS-1:0] rdata;

    assign cfg_ready = state == LOAD;
    assign tbl_ready = state == ARMED;
    // a beat coinciding with cfg_start belongs to the aborted load and is dropped
    assign we        = cfg_ready & cfg_valid & ~cfg_start;
    assign re        = m0_valid & tbl_ready;
    assign M1        = m1_valid ? rdata : '0;

    lut_neuron_ram #(
        .IN_BITS      (IN_BITS),
        .OUT_BITS     (OUT_BITS),
        .BEAT_ENTRIES (BEAT_ENTRIES)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (beat_cnt),
        .wdata (cfg_data),
        .re    (re),
        .raddr (M0),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            cfg_err  <= 1'b0;
            m1_valid <= 1'b0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
            cfg_err  <= err_n;
            m1_valid <= re;
        end
    end

    // beat_cnt all-ones marks the final beat of the table
    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        err_n      = cfg_err;
        if (cfg_start) begin
            state_n    = LOAD;
            beat_cnt_n = '0;
            err_n      = 1'b0;
        end else if (we) begin
            beat_cnt_n = beat_cnt + 1'b1;
            if (&beat_cnt) begin
                state_n = cfg_last ? ARMED : IDLE;
                err_n   = ~cfg_last;
            end else if (cfg_last) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// tb_lut_neuron_table_loader: self-checking bench with a spec-level table model
module tb_lut_neuron_table_loader;
    logic       clk = 0, rst_n = 0, cfg_start = 0, cfg_valid = 0, cfg_last = 0, m0_valid = 0;
    logic [7:0] cfg_data = '0;
    logic [5:0] M0 = '0;
    logic       cfg_ready, cfg_err, tbl_ready, m1_valid;
    logic [1:0] M1;

    lut_neuron_table_loader dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_last(cfg_last), .cfg_err(cfg_err),
        .tbl_ready(tbl_ready), .M0(M0), .m0_valid(m0_valid), .M1(M1), .m1_valid(m1_valid)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [1:0] ref_tbl [64];
    bit loading, armed, err;
    int cnt;

    typedef struct {
        logic [5:0] a;
        logic       v;
        logic       ev;
        logic [1:0] em;
    } vec_t;
    vec_t vecs [8];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic model_reset;
        loading = 0; armed = 0; err = 0; cnt = 0;
    endtask

    task automatic model_start;
        loading = 1; armed = 0; err = 0; cnt = 0;
    endtask

    task automatic status(input string n);
        chk({n, "_cfg_ready"}, cfg_ready, loading);
        chk({n, "_tbl_ready"}, tbl_ready, armed);
        chk({n, "_cfg_err"}, cfg_err, err);
    endtask

    task automatic start;
        cfg_start = 1;
        tick();
        cfg_start = 0;
        model_start();
        status("start");
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        chk("cfg_ready_pre_beat", cfg_ready, loading);
        cfg_valid = 1; cfg_data = d; cfg_last = last;
        tick();
        cfg_valid = 0; cfg_last = 0; cfg_data = 8'($urandom);
        if (loading) begin
            for (int k = 0; k < 4; k++) ref_tbl[cnt*4+k] = d[k*2 +: 2];
            if (cnt == 15) begin
                loading = 0; armed = last; err = !last;
            end else if (last) begin
                loading = 0; err = 1;
            end
            cnt++;
        end
    endtask

    task automatic lookup(input logic [5:0] a, input logic v);
        logic       ev;
        logic [1:0] em;
        ev = v && armed;
        em = ev ? ref_tbl[a] : 2'd0;
        M0 = a; m0_valid = v;
        tick();
        m0_valid = 0;
        chk("lookup_m1_valid", m1_valid, ev);
        chk("lookup_M1", M1, em);
    endtask

    task automatic run_vecs;
        for (int i = 0; i < 8; i++) begin
            M0 = vecs[i].a; m0_valid = vecs[i].v;
            tick();
            m0_valid = 0;
            chk("vec_m1_valid", m1_valid, vecs[i].ev);
            chk("vec_M1", M1, vecs[i].em);
        end
    endtask

    initial begin
        vecs[0] = '{6'd5,  1'b1, 1'b1, 2'd1};
        vecs[1] = '{6'd63, 1'b1, 1'b1, 2'd3};
        vecs[2] = '{6'd0,  1'b1, 1'b1, 2'd0};
        vecs[3] = '{6'd2,  1'b1, 1'b1, 2'd2};
        vecs[4] = '{6'd7,  1'b0, 1'b0, 2'd0};
        vecs[5] = '{6'd42, 1'b1, 1'b1, 2'd2};
        vecs[6] = '{6'd25, 1'b1, 1'b1, 2'd1};
        vecs[7] = '{6'd6,  1'b1, 1'b1, 2'd2};
        model_reset();
        repeat (2) tick();
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_tbl_ready", tbl_ready, 0);
        chk("rst_m1_valid", m1_valid, 0);
        chk("rst_M1", M1, 0);
        rst_n = 1;
        tick();

        // lookup before any load is dropped
        lookup(6'd5, 1'b1);
        chk("t1_tbl_ready", tbl_ready, 0);

        // full load of the pattern entry i = i[1:0]
        start();
        for (int b = 0; b < 16; b++) beat(8'b11_10_01_00, b == 15);
        chk("t2_tbl_ready", tbl_ready, 1);
        chk("t2_cfg_ready", cfg_ready, 0);
        run_vecs();

        // early cfg_last is a framing error
        start();
        for (int b = 0; b < 4; b++) beat(8'($urandom), b == 3);
        chk("t3_cfg_err", cfg_err, 1);
        chk("t3_tbl_ready", tbl_ready, 0);
        chk("t3_cfg_ready", cfg_ready, 0);
        lookup(6'd9, 1'b1);
        start();
        chk("t3_err_cleared", cfg_err, 0);

        // restart at beat 7; the beat accepted with cfg_start is discarded
        for (int b = 0; b < 7; b++) beat(8'($urandom), 1'b0);
        cfg_start = 1; cfg_valid = 1; cfg_data = 8'hFF;
        tick();
        cfg_start = 0; cfg_valid = 0;
        model_start();
        status("t4_restart");
        for (int b = 0; b < 16; b++) beat(8'h1B, b == 15);
        M0 = 6'd0; m0_valid = 1;
        tick();
        m0_valid = 0;
        chk("t4_M1_addr0", M1, 2'b11);
        for (int i = 0; i < 12; i++) lookup(6'($urandom), 1'($urandom));

        // final beat without cfg_last is also a framing error
        start();
        for (int b = 0; b < 16; b++) beat(8'($urandom), 1'b0);
        status("t3b_no_last");
        chk("t3b_cfg_err", cfg_err, 1);

        // load with gaps reproduces the first table
        start();
        for (int b = 0; b < 16; b++) begin
            beat(8'hE4, b == 15);
            if (b != 15) begin
                cfg_data = 8'($urandom);
                tick();
                status("t5_gap");
            end
        end
        run_vecs();

        // lookup alongside cfg_start in ARMED completes from the old table
        M0 = 6'd63; m0_valid = 1; cfg_start = 1;
        tick();
        m0_valid = 0; cfg_start = 0;
        chk("arm_restart_m1_valid", m1_valid, 1);
        chk("arm_restart_M1", M1, 2'b11);
        chk("arm_restart_tbl_ready", tbl_ready, 0);
        model_start();
        lookup(6'd5, 1'b1);

        // async reset mid-load
        for (int b = 0; b < 9; b++) beat(8'($urandom), 1'b0);
        #3 rst_n = 0;
        #1;
        chk("t6_cfg_ready", cfg_ready, 0);
        chk("t6_tbl_ready", tbl_ready, 0);
        chk("t6_cfg_err", cfg_err, 0);
        chk("t6_m1_valid", m1_valid, 0);
        chk("t6_M1", M1, 0);
        model_reset();
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) lookup(6'($urandom), 1'b1);
        status("t6_after");

        // randomized loads, gaps, framing and lookups against the model
        for (int r = 0; r < 6; r++) begin
            int lastb;
            lastb = (r % 3 == 2) ? int'($urandom_range(0, 15)) : 15;
            start();
            for (int b = 0; b <= lastb; b++) begin
                beat(8'($urandom), b == lastb);
                if ($urandom_range(0, 1) == 1) tick();
            end
            status("rnd_end");
            for (int i = 0; i < 30; i++) lookup(6'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
